pdp8_mem_arbiter: RTL and testbench

- Shares the single-port 4096x12 PDP8 memory between the instruction fetch unit and the execution unit.
- IFU has one read port; EXEC has one read port and one write port.
- Performs request/ack arbitration with one access in flight at a time, and holds each port's read data until that port's next ack.
- Sits between pdp8 IFU/EXEC and the memory model. The responder becomes a slave behind mem_* ports.

---
 rtl/pdp8_pkg.sv | 20 ++
 rtl/pdp8_arb_prio.sv | 26 ++
 rtl/pdp8_mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_pdp8_mem_arbiter.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdp8_pkg.sv
// pdp8_pkg: shared types and constants for the PDP8 memory arbiter.
//   arb_state_t    - arbiter FSM state (IDLE, ISSUE, WAIT, RESP)
//   arb_owner_t    - which port owns the access in flight
//   ARB_STAT_WIDTH - width of the optional statistics counters
//   arb_sat_inc()  - saturating increment used by the statistics counters
package pdp8_pkg;

   typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_IFU, OWN_EXEC_RD, OWN_EXEC_WR} arb_owner_t;

   localparam int ARB_STAT_WIDTH   = 16;
   // Wait counter covers MEM_LATENCY 1..7, starve counter covers STARVE_LIMIT 1..15.
   localparam int ARB_WAIT_WIDTH   = 3;
   localparam int ARB_STARVE_WIDTH = 4;

   function automatic logic [ARB_STAT_WIDTH-1:0] arb_sat_inc(input logic [ARB_STAT_WIDTH-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/pdp8_arb_prio.sv
// pdp8_arb_prio: combinational winner select for the PDP8 memory arbiter.
// Ports:
//   ifu_rd_req, exec_rd_req, exec_wr_req - pending requests
//   starve_force                         - IFU has waited out the starvation limit
//   owner                                - winning port, OWN_NONE when idle
// Priority is exec_wr > exec_rd > ifu_rd, except that a forced IFU wins outright.
// Putting the write ahead of the read keeps a same-cycle write/read pair RAW-safe.
module pdp8_arb_prio
   import pdp8_pkg::*;
(
   input  logic       ifu_rd_req,
   input  logic       exec_rd_req,
   input  logic       exec_wr_req,
   input  logic       starve_force,
   output arb_owner_t owner
);

   always_comb begin
      owner = OWN_NONE;
      if (starve_force && ifu_rd_req) owner = OWN_IFU;
      else if (exec_wr_req)           owner = OWN_EXEC_WR;
      else if (exec_rd_req)           owner = OWN_EXEC_RD;
      else if (ifu_rd_req)            owner = OWN_IFU;
   end

endmodule

// File: rtl/pdp8_mem_arbiter.sv
// pdp8_mem_arbiter: shares the single-port PDP8 memory between IFU and EXEC.
// One access is in flight at a time: IDLE (grant) -> ISSUE (mem_en) ->
// WAIT (MEM_LATENCY cycles) -> RESP (one-cycle ack) -> IDLE.
// Handshake: each requester holds its level req (with stable addr/data) until
// its one-cycle ack; a req still high in the cycle after ack is a new request.
// Address and write data are sampled only at grant in IDLE.
// Ports:
//   clk, reset_n                     - clock, async active-low reset
//   ifu_rd_*                         - IFU read port (req/addr in, data/ack out)
//   exec_rd_*                        - EXEC read port
//   exec_wr_*                        - EXEC write port
//   mem_en/we/addr/wdata, mem_rdata  - memory side
//   ifu_grant_cnt, exec_grant_cnt,
//   starve_evt_cnt                   - statistics, only with PDP8_ARB_STATS_EN
//   dbg_state, dbg_starve_cnt        - FSM state and starvation counter
// Optional feature macro: PDP8_ARB_STATS_EN.
module pdp8_mem_arbiter
   import pdp8_pkg::*;
#(
   parameter int ADDR_WIDTH   = 12,
   parameter int DATA_WIDTH   = 12,
   parameter int MEM_LATENCY  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        ifu_rd_req,
   input  logic [ADDR_WIDTH-1:0]       ifu_rd_addr,
   output logic [DATA_WIDTH-1:0]       ifu_rd_data,
   output logic                        ifu_rd_ack,
   input  logic                        exec_rd_req,
   input  logic [ADDR_WIDTH-1:0]       exec_rd_addr,
   output logic [DATA_WIDTH-1:0]       exec_rd_data,
   output logic                        exec_rd_ack,
   input  logic                        exec_wr_req,
   input  logic [ADDR_WIDTH-1:0]       exec_wr_addr,
   input  logic [DATA_WIDTH-1:0]       exec_wr_data,
   output logic                        exec_wr_ack,
   output logic                        mem_en,
   output logic                        mem_we,
   output logic [ADDR_WIDTH-1:0]       mem_addr,
   output logic [DATA_WIDTH-1:0]       mem_wdata,
   input  logic [DATA_WIDTH-1:0]       mem_rdata,
`ifdef PDP8_ARB_STATS_EN
   output logic [ARB_STAT_WIDTH-1:0]   ifu_grant_cnt,
   output logic [ARB_STAT_WIDTH-1:0]   exec_grant_cnt,
   output logic [ARB_STAT_WIDTH-1:0]   starve_evt_cnt,
`endif
   output arb_state_t                  dbg_state,
   output logic [ARB_STARVE_WIDTH-1:0] dbg_starve_cnt
);

   localparam logic [ARB_WAIT_WIDTH-1:0]   LAT_LOAD = ARB_WAIT_WIDTH'(MEM_LATENCY);
   localparam logic [ARB_WAIT_WIDTH-1:0]   WAIT_END = ARB_WAIT_WIDTH'(1);
   localparam logic [ARB_STARVE_WIDTH-1:0] LIMIT    = ARB_STARVE_WIDTH'(STARVE_LIMIT);

   arb_state_t                  state;
   arb_owner_t                  owner_q;
   arb_owner_t                  win;
   logic [ARB_WAIT_WIDTH-1:0]   wait_cnt;
   logic [ARB_STARVE_WIDTH-1:0] starve_cnt;
   logic                        starve_force;
   logic                        grant;

   assign starve_force   = (starve_cnt == LIMIT);
   assign grant          = (state == ARB_IDLE) && (win != OWN_NONE);
   assign dbg_state      = state;
   assign dbg_starve_cnt = starve_cnt;

   pdp8_arb_prio u_prio (
      .ifu_rd_req   (ifu_rd_req),
      .exec_rd_req  (exec_rd_req),
      .exec_wr_req  (exec_wr_req),
      .starve_force (starve_force),
      .owner        (win)
   );

   // Main FSM. The mem_* registers double as the latched grant: they are
   // loaded at grant so they are live during ISSUE and zeroed when leaving it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ARB_IDLE;
         owner_q      <= OWN_NONE;
         wait_cnt     <= '0;
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         ifu_rd_ack   <= 1'b0;
         exec_rd_ack  <= 1'b0;
         exec_wr_ack  <= 1'b0;
         ifu_rd_data  <= '0;
         exec_rd_data <= '0;
      end else begin
         ifu_rd_ack  <= 1'b0;
         exec_rd_ack <= 1'b0;
         exec_wr_ack <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (grant) begin
                  owner_q   <= win;
                  mem_en    <= 1'b1;
                  mem_we    <= (win == OWN_EXEC_WR);
                  mem_wdata <= (win == OWN_EXEC_WR) ? exec_wr_data : '0;
                  case (win)
                     OWN_IFU:     mem_addr <= ifu_rd_addr;
                     OWN_EXEC_RD: mem_addr <= exec_rd_addr;
                     default:     mem_addr <= exec_wr_addr;
                  endcase
                  state <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               mem_en    <= 1'b0;
               mem_we    <= 1'b0;
               mem_addr  <= '0;
               mem_wdata <= '0;
               wait_cnt  <= LAT_LOAD;
               state     <= ARB_WAIT;
            end
            ARB_WAIT: begin
               // The ack is registered here so it is high exactly during RESP,
               // together with the freshly captured read data.
               if (wait_cnt == WAIT_END) begin
                  case (owner_q)
                     OWN_IFU: begin
                        ifu_rd_data <= mem_rdata;
                        ifu_rd_ack  <= 1'b1;
                     end
                     OWN_EXEC_RD: begin
                        exec_rd_data <= mem_rdata;
                        exec_rd_ack  <= 1'b1;
                     end
                     OWN_EXEC_WR: exec_wr_ack <= 1'b1;
                     default: ;
                  endcase
                  state <= ARB_RESP;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            default: begin
               owner_q <= OWN_NONE;
               state   <= ARB_IDLE;
            end
         endcase
      end
   end

   // Starvation counter: counts EXEC grants taken while IFU is waiting.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         starve_cnt <= '0;
      end else if (grant) begin
         if (win == OWN_IFU || !ifu_rd_req) starve_cnt <= '0;
         else if (starve_cnt != LIMIT)      starve_cnt <= starve_cnt + 1'b1;
      end else if (!ifu_rd_req) begin
         starve_cnt <= '0;
      end
   end

`ifdef PDP8_ARB_STATS_EN
   // A forced grant counts as a starvation event only when EXEC actually lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ifu_grant_cnt  <= '0;
         exec_grant_cnt <= '0;
         starve_evt_cnt <= '0;
      end else if (grant) begin
         if (win == OWN_IFU) ifu_grant_cnt  <= arb_sat_inc(ifu_grant_cnt);
         else                exec_grant_cnt <= arb_sat_inc(exec_grant_cnt);
         if (win == OWN_IFU && starve_force && (exec_rd_req || exec_wr_req))
            starve_evt_cnt <= arb_sat_inc(starve_evt_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_pdp8_mem_arbiter.sv
// tb_pdp8_mem_arbiter: bench for pdp8_mem_arbiter. Instance dut uses
// MEM_LATENCY=1, instance dut_b uses MEM_LATENCY=3. Each has a memory model
// with a read pipeline of its latency; ref_mem holds the expected contents.
module tb_pdp8_mem_arbiter;
   import pdp8_pkg::*;

   localparam int AW = 12;
   localparam int DW = 12;
   localparam int LAT_A = 1;
   localparam int LAT_B = 3;
   localparam int LIMIT = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   // ---------------- instance a signals ----------------
   logic ifu_rd_req = 1'b0, exec_rd_req = 1'b0, exec_wr_req = 1'b0;
   logic [AW-1:0] ifu_rd_addr = '0, exec_rd_addr = '0, exec_wr_addr = '0;
   logic [DW-1:0] exec_wr_data = '0;
   logic [DW-1:0] ifu_rd_data, exec_rd_data, mem_wdata, mem_rdata;
   logic ifu_rd_ack, exec_rd_ack, exec_wr_ack, mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   arb_state_t dbg_state;
   logic [ARB_STARVE_WIDTH-1:0] dbg_starve_cnt;

   // ---------------- instance b signals ----------------
   logic b_ifu_rd_req = 1'b0;
   logic [AW-1:0] b_ifu_rd_addr = '0;
   logic b_zero = 1'b0;
   logic [AW-1:0] b_zero_a = '0;
   logic [DW-1:0] b_ifu_rd_data, b_exec_rd_data, b_mem_wdata, b_mem_rdata;
   logic b_ifu_rd_ack, b_exec_rd_ack, b_exec_wr_ack, b_mem_en, b_mem_we;
   logic [AW-1:0] b_mem_addr;
   arb_state_t b_dbg_state;
   logic [ARB_STARVE_WIDTH-1:0] b_dbg_starve_cnt;

`ifdef PDP8_ARB_STATS_EN
   logic [ARB_STAT_WIDTH-1:0] ifu_grant_cnt, exec_grant_cnt, starve_evt_cnt;
   logic [ARB_STAT_WIDTH-1:0] b_ifu_grant_cnt, b_exec_grant_cnt, b_starve_evt_cnt;
`endif

   pdp8_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT_A), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .reset_n(reset_n),
      .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr), .ifu_rd_data(ifu_rd_data), .ifu_rd_ack(ifu_rd_ack),
      .exec_rd_req(exec_rd_req), .exec_rd_addr(exec_rd_addr), .exec_rd_data(exec_rd_data), .exec_rd_ack(exec_rd_ack),
      .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr), .exec_wr_data(exec_wr_data), .exec_wr_ack(exec_wr_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef PDP8_ARB_STATS_EN
      .ifu_grant_cnt(ifu_grant_cnt), .exec_grant_cnt(exec_grant_cnt), .starve_evt_cnt(starve_evt_cnt),
`endif
      .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
   );

   pdp8_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT_B), .STARVE_LIMIT(LIMIT)) dut_b (
      .clk(clk), .reset_n(reset_n),
      .ifu_rd_req(b_ifu_rd_req), .ifu_rd_addr(b_ifu_rd_addr), .ifu_rd_data(b_ifu_rd_data), .ifu_rd_ack(b_ifu_rd_ack),
      .exec_rd_req(b_zero), .exec_rd_addr(b_zero_a), .exec_rd_data(b_exec_rd_data), .exec_rd_ack(b_exec_rd_ack),
      .exec_wr_req(b_zero), .exec_wr_addr(b_zero_a), .exec_wr_data(b_zero_a), .exec_wr_ack(b_exec_wr_ack),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
`ifdef PDP8_ARB_STATS_EN
      .ifu_grant_cnt(b_ifu_grant_cnt), .exec_grant_cnt(b_exec_grant_cnt), .starve_evt_cnt(b_starve_evt_cnt),
`endif
      .dbg_state(b_dbg_state), .dbg_starve_cnt(b_dbg_starve_cnt)
   );

   // ---------------- memory models ----------------
   function automatic logic [DW-1:0] pat(input int i);
      return DW'(i * 1237 + 291);
   endfunction

   logic [DW-1:0] mem_a [4096];
   logic [DW-1:0] mem_b [4096];
   logic [DW-1:0] pipe_a [LAT_A];
   logic [DW-1:0] pipe_b [LAT_B];
   bit init_done = 1'b0;
   logic bd_we = 1'b0;
   logic [AW-1:0] bd_addr = '0;
   logic [DW-1:0] bd_data = '0;

   // Read data is garbage except exactly MEM_LATENCY cycles after a read strobe.
   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 4096; i++) begin
            mem_a[i] <= pat(i);
            mem_b[i] <= pat(i);
         end
         init_done <= 1'b1;
      end
      pipe_a[0] <= (mem_en && !mem_we) ? mem_a[mem_addr] : DW'($urandom);
      for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
      pipe_b[0] <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr] : DW'($urandom);
      for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
      if (mem_en && mem_we) mem_a[mem_addr] <= mem_wdata;
      if (b_mem_en && b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;
      if (bd_we) begin
         mem_a[bd_addr] <= bd_data;
         mem_b[bd_addr] <= bd_data;
      end
   end
   assign mem_rdata   = pipe_a[LAT_A-1];
   assign b_mem_rdata = pipe_b[LAT_B-1];

   // ---------------- reference model / scoreboard ----------------
   logic [DW-1:0] ref_mem [4096];
   logic [DW-1:0] exp_q [$];

   // ---------------- driver tasks ----------------
   task automatic apply_reset();
      @(negedge clk);
      reset_n = 1'b0;
      ifu_rd_req = 1'b0; exec_rd_req = 1'b0; exec_wr_req = 1'b0; b_ifu_rd_req = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic backdoor(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      ref_mem[a] = d;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   // Counts negedges until the chosen ack is seen; 0 ifu, 1 exec_rd, 2 exec_wr, 3 b ifu.
   task automatic wait_ack(input int which, input int max_cyc, output int n, output bit got);
      n = 0; got = 1'b0;
      while (!got && n < max_cyc) begin
         @(negedge clk);
         n++;
         case (which)
            0: got = ifu_rd_ack;
            1: got = exec_rd_ack;
            2: got = exec_wr_ack;
            default: got = b_ifu_rd_ack;
         endcase
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({ifu_rd_data, exec_rd_data} !== '0) begin
         n_fail++; $display("FAIL reset_data: got %h/%h expected 0/0", ifu_rd_data, exec_rd_data);
      end
      n_checks++;
      if ({ifu_rd_ack, exec_rd_ack, exec_wr_ack} !== 3'b000) begin
         n_fail++; $display("FAIL reset_acks: got %b expected 000", {ifu_rd_ack, exec_rd_ack, exec_wr_ack});
      end
      n_checks++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !== '0) begin
         n_fail++; $display("FAIL reset_mem: got en=%b we=%b addr=%h wd=%h expected all 0", mem_en, mem_we, mem_addr, mem_wdata);
      end
      n_checks++;
      if (dbg_state !== ARB_IDLE || dbg_starve_cnt !== 4'd0) begin
         n_fail++; $display("FAIL reset_state: got state=%0d starve=%0d expected 0/0", dbg_state, dbg_starve_cnt);
      end
      n_checks++;
      if ({b_ifu_rd_data, b_ifu_rd_ack, b_mem_en} !== '0) begin
         n_fail++; $display("FAIL reset_b: got data=%h ack=%b en=%b expected 0", b_ifu_rd_data, b_ifu_rd_ack, b_mem_en);
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_ifu();
      backdoor(12'o0200, 12'o7402);
      ifu_rd_req = 1'b1; ifu_rd_addr = 12'o0200;   // cycle 0
      @(negedge clk);                              // cycle 1
      n_checks++;
      if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'o0200) begin
         n_fail++; $display("FAIL single_issue: got en=%b we=%b addr=%o expected 1/0/0200", mem_en, mem_we, mem_addr);
      end
      @(negedge clk);                              // cycle 2
      n_checks++;
      if (mem_en !== 1'b0 || mem_addr !== '0 || ifu_rd_ack !== 1'b0) begin
         n_fail++; $display("FAIL single_wait: got en=%b addr=%o ack=%b expected 0/0/0", mem_en, mem_addr, ifu_rd_ack);
      end
      @(negedge clk);                              // cycle 3
      n_checks++;
      if (ifu_rd_ack !== 1'b1 || ifu_rd_data !== 12'o7402) begin
         n_fail++; $display("FAIL single_ack: got ack=%b data=%o expected 1/7402", ifu_rd_ack, ifu_rd_data);
      end
      n_checks++;
      if (exec_rd_ack !== 1'b0 || exec_wr_ack !== 1'b0) begin
         n_fail++; $display("FAIL single_other_acks: got %b%b expected 00", exec_rd_ack, exec_wr_ack);
      end
      ifu_rd_req = 1'b0;
      @(negedge clk);                              // cycle 4
      n_checks++;
      if (ifu_rd_ack !== 1'b0 || ifu_rd_data !== 12'o7402) begin
         n_fail++; $display("FAIL single_after: got ack=%b data=%o expected 0/7402", ifu_rd_ack, ifu_rd_data);
      end
   endtask

   task automatic test_raw_order();
      int wr_cyc, rd_cyc;
      wr_cyc = -1; rd_cyc = -1;
      exec_wr_req = 1'b1; exec_wr_addr = 12'o0050; exec_wr_data = 12'o1234;
      exec_rd_req = 1'b1; exec_rd_addr = 12'o0050;
      for (int c = 1; c <= 20 && rd_cyc < 0; c++) begin
         @(negedge clk);
         if (exec_wr_ack) begin
            wr_cyc = c;
            exec_wr_req = 1'b0;
            ref_mem[12'o0050] = 12'o1234;
            n_checks++;
            if (exec_rd_data !== 12'o0000) begin
               n_fail++; $display("FAIL raw_wr_disturb: got exec_rd_data=%o expected 0000", exec_rd_data);
            end
         end
         if (exec_rd_ack) begin
            rd_cyc = c;
            exec_rd_req = 1'b0;
            n_checks++;
            if (exec_rd_data !== 12'o1234) begin
               n_fail++; $display("FAIL raw_rd_data: got %o expected 1234", exec_rd_data);
            end
         end
      end
      exec_wr_req = 1'b0; exec_rd_req = 1'b0;
      n_checks++;
      if (wr_cyc != 3) begin
         n_fail++; $display("FAIL raw_wr_latency: got cycle %0d expected 3", wr_cyc);
      end
      n_checks++;
      if (rd_cyc != wr_cyc + 3 + LAT_A) begin
         n_fail++; $display("FAIL raw_rd_after_wr: got rd cycle %0d expected %0d", rd_cyc, wr_cyc + 3 + LAT_A);
      end
      @(negedge clk);
   endtask

   task automatic test_starve();
      int sc, n;
      bit exp_ifu, obs_ifu, got;
      logic [AW-1:0] ia, ea;
      logic [DW-1:0] exp_d, obs_d;
      sc = 0;
      ia = AW'($urandom); ea = AW'($urandom);
      ifu_rd_req = 1'b1; ifu_rd_addr = ia;
      exec_rd_req = 1'b1; exec_rd_addr = ea;
      for (int g = 0; g < 10; g++) begin
         // IFU wins once LIMIT EXEC grants have gone by with IFU waiting.
         exp_ifu = (sc >= LIMIT);
         sc = exp_ifu ? 0 : sc + 1;
         got = 1'b0; n = 0;
         while (!got && n < 12) begin
            @(negedge clk);
            n++;
            got = ifu_rd_ack | exec_rd_ack;
         end
         n_checks++;
         if (!got) begin
            n_fail++; $display("FAIL starve_timeout: grant %0d got no ack expected one", g);
         end else begin
            obs_ifu = ifu_rd_ack;
            n_checks++;
            if (obs_ifu !== exp_ifu) begin
               n_fail++; $display("FAIL starve_order: grant %0d got ifu=%b expected ifu=%b", g, obs_ifu, exp_ifu);
            end
            exp_d = obs_ifu ? ref_mem[ia] : ref_mem[ea];
            obs_d = obs_ifu ? ifu_rd_data : exec_rd_data;
            n_checks++;
            if (obs_d !== exp_d) begin
               n_fail++; $display("FAIL starve_data: grant %0d got %o expected %o", g, obs_d, exp_d);
            end
            if (obs_ifu) begin
               n_checks++;
               if (dbg_starve_cnt !== 4'd0) begin
                  n_fail++; $display("FAIL starve_clear: got %0d expected 0", dbg_starve_cnt);
               end
               ia = AW'($urandom); ifu_rd_addr = ia;
            end else begin
               ea = AW'($urandom); exec_rd_addr = ea;
            end
         end
      end
      ifu_rd_req = 1'b0; exec_rd_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int n;
      bit got, any_ack;
      logic [AW-1:0] a;
      ifu_rd_req = 1'b1; ifu_rd_addr = AW'($urandom);
      repeat (2) @(negedge clk);
      n_checks++;
      if (dbg_state !== ARB_WAIT) begin
         n_fail++; $display("FAIL mid_in_wait: got state %0d expected %0d", dbg_state, ARB_WAIT);
      end
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({ifu_rd_data, exec_rd_data, ifu_rd_ack, exec_rd_ack, exec_wr_ack, mem_en, mem_we, mem_addr, mem_wdata} !== '0
          || dbg_state !== ARB_IDLE) begin
         n_fail++; $display("FAIL mid_async_clear: got ifu=%o exec=%o en=%b state=%0d expected all 0", ifu_rd_data, exec_rd_data, mem_en, dbg_state);
      end
      ifu_rd_req = 1'b0;
      any_ack = 1'b0;
      repeat (2) begin
         @(negedge clk);
         any_ack |= ifu_rd_ack | exec_rd_ack | exec_wr_ack;
      end
      reset_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         any_ack |= ifu_rd_ack | exec_rd_ack | exec_wr_ack;
      end
      n_checks++;
      if (any_ack) begin
         n_fail++; $display("FAIL mid_no_ack: got an ack after abort expected none");
      end
      a = AW'($urandom);
      ifu_rd_req = 1'b1; ifu_rd_addr = a;
      wait_ack(0, 10, n, got);
      ifu_rd_req = 1'b0;
      n_checks++;
      if (!got || n != 2 + LAT_A) begin
         n_fail++; $display("FAIL mid_recover_latency: got %0d cycles (ack=%b) expected %0d", n, got, 2 + LAT_A);
      end
      n_checks++;
      if (ifu_rd_data !== ref_mem[a]) begin
         n_fail++; $display("FAIL mid_recover_data: got %o expected %o", ifu_rd_data, ref_mem[a]);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int n;
      bit got, hold_ok;
      logic [DW-1:0] v0, v1;
      v0 = DW'($urandom); v1 = ~v0;
      backdoor(12'o0000, v0);
      backdoor(12'o0001, v1);
      b_ifu_rd_req = 1'b1; b_ifu_rd_addr = 12'o0000;
      wait_ack(3, 12, n, got);
      n_checks++;
      if (!got || n != 2 + LAT_B || b_ifu_rd_data !== v0) begin
         n_fail++; $display("FAIL b2b_first: got %0d cycles data=%o expected %0d cycles data=%o", n, b_ifu_rd_data, 2 + LAT_B, v0);
      end
      // Req stays high across the ack: that is the second request.
      b_ifu_rd_addr = 12'o0001;
      hold_ok = 1'b1; got = 1'b0; n = 0;
      while (!got && n < 15) begin
         @(negedge clk);
         n++;
         got = b_ifu_rd_ack;
         if (!got && b_ifu_rd_data !== v0) hold_ok = 1'b0;
      end
      b_ifu_rd_req = 1'b0;
      n_checks++;
      if (!got || n != 3 + LAT_B) begin
         n_fail++; $display("FAIL b2b_spacing: got %0d cycles expected %0d", n, 3 + LAT_B);
      end
      n_checks++;
      if (!hold_ok) begin
         n_fail++; $display("FAIL b2b_hold: got data change before 2nd ack expected %o held", v0);
      end
      n_checks++;
      if (b_ifu_rd_data !== v1) begin
         n_fail++; $display("FAIL b2b_second: got %o expected %o", b_ifu_rd_data, v1);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [DW-1:0] exp_ifu_d, exp_exec_d, d;
      logic [AW-1:0] a;
      int kind, n;
      bit got;
      apply_reset();
      exp_ifu_d = '0; exp_exec_d = '0;
      for (int k = 0; k < 24; k++) begin
         kind = $urandom_range(0, 2);
         a = AW'($urandom); d = DW'($urandom);
         case (kind)
            0: begin ifu_rd_req = 1'b1; ifu_rd_addr = a; exp_q.push_back(ref_mem[a]); end
            1: begin exec_rd_req = 1'b1; exec_rd_addr = a; exp_q.push_back(ref_mem[a]); end
            default: begin exec_wr_req = 1'b1; exec_wr_addr = a; exec_wr_data = d; end
         endcase
         wait_ack(kind, 10, n, got);
         ifu_rd_req = 1'b0; exec_rd_req = 1'b0; exec_wr_req = 1'b0;
         n_checks++;
         if (!got || n != 2 + LAT_A) begin
            n_fail++; $display("FAIL rand_latency: op %0d kind %0d got %0d cycles (ack=%b) expected %0d", k, kind, n, got, 2 + LAT_A);
         end
         if (kind == 2) ref_mem[a] = d;
         else if (kind == 0) exp_ifu_d = exp_q.pop_front();
         else exp_exec_d = exp_q.pop_front();
         n_checks++;
         if (ifu_rd_data !== exp_ifu_d) begin
            n_fail++; $display("FAIL rand_ifu_data: op %0d got %o expected %o", k, ifu_rd_data, exp_ifu_d);
         end
         n_checks++;
         if (exec_rd_data !== exp_exec_d) begin
            n_fail++; $display("FAIL rand_exec_data: op %0d got %o expected %o", k, exec_rd_data, exp_exec_d);
         end
         @(negedge clk);
      end
   endtask

`ifdef PDP8_ARB_STATS_EN
   task automatic test_stats();
      int n;
      bit got;
      apply_reset();
      n_checks++;
      if ({ifu_grant_cnt, exec_grant_cnt, starve_evt_cnt} !== '0) begin
         n_fail++; $display("FAIL stats_reset: got %0d/%0d/%0d expected 0/0/0", ifu_grant_cnt, exec_grant_cnt, starve_evt_cnt);
      end
      for (int k = 0; k < 15; k++) begin
         if (k < 10) begin ifu_rd_req = 1'b1; ifu_rd_addr = AW'($urandom); wait_ack(0, 10, n, got); end
         else begin exec_rd_req = 1'b1; exec_rd_addr = AW'($urandom); wait_ack(1, 10, n, got); end
         ifu_rd_req = 1'b0; exec_rd_req = 1'b0;
         @(negedge clk);
      end
      n_checks++;
      if (ifu_grant_cnt !== 16'd10 || exec_grant_cnt !== 16'd5 || starve_evt_cnt !== 16'd0) begin
         n_fail++; $display("FAIL stats_counts: got %0d/%0d/%0d expected 10/5/0", ifu_grant_cnt, exec_grant_cnt, starve_evt_cnt);
      end
   endtask
`endif

   // ---------------- sequence and report ----------------
   initial begin
      for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);
      test_reset();
      test_single_ifu();
      test_raw_order();
      test_starve();
      test_reset_mid();
      test_back_to_back();
      test_random();
`ifdef PDP8_ARB_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running at time limit, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
